// File: rtl/rr_burst_arbiter.sv
// rtl/rr_burst_arbiter.sv - N-way round-robin bus arbiter with burst hold, hold-limit preemption and lock
module rr_burst_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         lock,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       preempt
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    // Hold limit in counter width; with preemption disabled the counter never leaves 0.
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE = (MAX_HOLD != 0) ? CNT_W'(1) : '0;
    localparam bit               HOLD_EN = (MAX_HOLD != 0);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    owner, owner_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [CNT_W-1:0]   hold_cnt, cnt_nxt;
    logic               preempt_nxt;
    logic               take;
    logic [NUM_REQ-1:0] take_mask;
    logic [NUM_REQ-1:0] others;
    logic [ID_W-1:0]    winner;

    // First set bit of mask, scanning circularly from start.
    function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] mask,
                                             input logic [ID_W-1:0]    start);
        logic [ID_W-1:0] w;
        logic [ID_W-1:0] cand;
        logic            found;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(start) + i) % NUM_REQ);
            if (!found && mask[cand]) begin
                w     = cand;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Index after w, wrapping at NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] w);
        return (w == ID_W'(NUM_REQ - 1)) ? '0 : w + ID_W'(1);
    endfunction

    // State register: owner, priority pointer, hold counter and the preempt pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= cnt_nxt;
            preempt  <= preempt_nxt;
        end
    end

    // Next-state: release beats preemption beats continuation; any new grant goes through one path.
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        ptr_nxt     = ptr;
        cnt_nxt     = hold_cnt;
        preempt_nxt = 1'b0;
        take        = 1'b0;
        take_mask   = req;
        others      = req & ~({{(NUM_REQ-1){1'b0}}, 1'b1} << owner);

        case (state)
            IDLE: begin
                if (|req) begin
                    take = 1'b1;
                end
            end
            OWNED: begin
                if (!req[owner]) begin
                    if (|others) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (HOLD_EN && (hold_cnt == MAX_CNT) && !lock[owner] && (|others)) begin
                    take        = 1'b1;
                    take_mask   = others;
                    preempt_nxt = 1'b1;
                end else if (hold_cnt != MAX_CNT) begin
                    cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        winner = pick(take_mask, ptr);
        if (take) begin
            state_nxt = OWNED;
            owner_nxt = winner;
            ptr_nxt   = wrap_inc(winner);
            cnt_nxt   = CNT_ONE;
        end
    end

    // Outputs decode purely from registered state, so they change only at clock edges.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        if (state == OWNED) begin
            grant       = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
            grant_id    = owner;
            grant_valid = 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// tb/tb_rr_burst_arbiter.sv - randomized and directed check of rr_burst_arbiter against a behavioural model
module tb_rr_burst_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] req5 = '0;
    logic [4:0] lock5 = '0;

    logic [3:0] g4, g0;
    logic [4:0] g5;
    logic       v4, v5, v0, p4, p5, p0;
    logic [1:0] id4, id0;
    logic [2:0] id5;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int owner;
        int ptr;
        int cnt;
        bit pre;
    } mdl_t;

    mdl_t m4, m5, m0;

    always #5 clk = ~clk;

    rr_burst_arbiter #(.NUM_REQ(4), .MAX_HOLD(4)) u4 (
        .clk(clk), .reset(reset), .req(req5[3:0]), .lock(lock5[3:0]),
        .grant(g4), .grant_valid(v4), .grant_id(id4), .preempt(p4)
    );

    rr_burst_arbiter #(.NUM_REQ(5), .MAX_HOLD(4)) u5 (
        .clk(clk), .reset(reset), .req(req5), .lock(lock5),
        .grant(g5), .grant_valid(v5), .grant_id(id5), .preempt(p5)
    );

    rr_burst_arbiter #(.NUM_REQ(4), .MAX_HOLD(0)) u0 (
        .clk(clk), .reset(reset), .req(req5[3:0]), .lock(lock5[3:0]),
        .grant(g0), .grant_valid(v0), .grant_id(id0), .preempt(p0)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Hand the bus to the first requester in mask, scanning circularly from ptr.
    function automatic mdl_t give(mdl_t m, int n, int unsigned mask);
        mdl_t x;
        int   idx;
        x = m;
        for (int k = 0; k < n; k++) begin
            idx = (m.ptr + k) % n;
            if (((mask >> idx) & 1) != 0) begin
                x.owner = idx;
                x.ptr   = (idx + 1) % n;
                x.cnt   = 1;
                return x;
            end
        end
        return x;
    endfunction

    // One clock edge of the arbiter's behaviour; owner -1 means the bus is idle.
    function automatic mdl_t mstep(mdl_t m, int n, int mh, int unsigned r, int unsigned l, bit rst);
        mdl_t        x;
        int unsigned others;
        x     = m;
        x.pre = 0;
        if (rst) begin
            x.owner = -1;
            x.ptr   = 0;
            x.cnt   = 0;
            return x;
        end
        if (m.owner < 0) begin
            if (r != 0) x = give(x, n, r);
        end else begin
            others = r & ~(32'd1 << m.owner);
            if (((r >> m.owner) & 1) == 0) begin
                if (others != 0) x = give(x, n, r);
                else x.owner = -1;
            end else if (mh != 0 && m.cnt >= mh && ((l >> m.owner) & 1) == 0 && others != 0) begin
                x     = give(x, n, others);
                x.pre = 1;
            end else if (x.cnt < mh) begin
                x.cnt = x.cnt + 1;
            end
        end
        return x;
    endfunction

    task automatic cmp(input string tag, input mdl_t m, input int unsigned g,
                       input int unsigned id, input logic v, input logic p);
        check({tag, ".grant"}, g, (m.owner < 0) ? 0 : (32'd1 << m.owner));
        check({tag, ".grant_id"}, id, (m.owner < 0) ? 0 : m.owner);
        check({tag, ".grant_valid"}, 32'(v), (m.owner < 0) ? 0 : 1);
        check({tag, ".preempt"}, 32'(p), 32'(m.pre));
    endtask

    // Advance one edge, step the models with the inputs seen at that edge, then compare.
    task automatic cycle();
        @(posedge clk);
        m4 = mstep(m4, 4, 4, 32'(req5[3:0]), 32'(lock5[3:0]), reset);
        m5 = mstep(m5, 5, 4, 32'(req5), 32'(lock5), reset);
        m0 = mstep(m0, 4, 0, 32'(req5[3:0]), 32'(lock5[3:0]), reset);
        #1;
        cmp("u4", m4, 32'(g4), 32'(id4), v4, p4);
        cmp("u5", m5, 32'(g5), 32'(id5), v5, p5);
        cmp("u0", m0, 32'(g0), 32'(id0), v0, p0);
    endtask

    task automatic expect4(input string tag, input int unsigned g, input int unsigned p);
        check({tag, ".g"}, 32'(g4), g);
        check({tag, ".p"}, 32'(p4), p);
    endtask

    task automatic rst_pulse();
        reset = 1'b1;
        req5  = '0;
        lock5 = '0;
        cycle();
        expect4("reset", 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        m4 = '{owner: -1, ptr: 0, cnt: 0, pre: 0};
        m5 = m4;
        m0 = m4;

        // Single requester: one-edge latency, no preemption without a contender.
        rst_pulse();
        check("reset.valid", 32'(v4), 0);
        req5 = 5'b00010;
        cycle();
        expect4("single_first", 4'b0010, 0);
        check("single_first.id", 32'(id4), 1);
        check("single_first.valid", 32'(v4), 1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            expect4("single_hold", 4'b0010, 0);
        end
        req5 = 5'b00000;
        cycle();
        expect4("single_drop", 0, 0);

        // Zero-gap hand-off around the ring.
        rst_pulse();
        req5 = 5'b01111;
        cycle();
        expect4("handoff0", 4'b0001, 0);
        req5 = 5'b01110;
        cycle();
        expect4("handoff1", 4'b0010, 0);
        req5 = 5'b01100;
        cycle();
        expect4("handoff2", 4'b0100, 0);
        req5 = 5'b01000;
        cycle();
        expect4("handoff3", 4'b1000, 0);
        req5 = 5'b00001;
        cycle();
        expect4("handoff_wrap", 4'b0001, 0);

        // Hold-limit preemption in both directions.
        rst_pulse();
        req5 = 5'b00101;
        cycle();
        expect4("pre_first", 4'b0001, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            expect4("pre_hold0", 4'b0001, 0);
        end
        cycle();
        expect4("pre_swap", 4'b0100, 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            expect4("pre_hold2", 4'b0100, 0);
        end
        cycle();
        expect4("pre_back", 4'b0001, 1);

        // Lock suppresses preemption until it drops.
        rst_pulse();
        lock5 = 5'b00001;
        req5  = 5'b00101;
        for (int i = 0; i < 22; i++) begin
            cycle();
            expect4("lock_hold", 4'b0001, 0);
        end
        lock5 = 5'b00000;
        cycle();
        expect4("lock_drop", 4'b0100, 1);

        // Simultaneous release and request, then re-request waits for the hold limit.
        rst_pulse();
        req5 = 5'b01000;
        cycle();
        expect4("sim_owner3", 4'b1000, 0);
        req5 = 5'b00001;
        cycle();
        expect4("sim_swap", 4'b0001, 0);
        req5 = 5'b01001;
        for (int i = 0; i < 3; i++) begin
            cycle();
            expect4("sim_hold", 4'b0001, 0);
        end
        cycle();
        expect4("sim_preempt", 4'b1000, 1);

        // Reset mid-burst clears everything including the pointer.
        rst_pulse();
        req5 = 5'b00100;
        for (int i = 0; i < 3; i++) begin
            cycle();
            expect4("mid_burst", 4'b0100, 0);
        end
        reset = 1'b1;
        cycle();
        expect4("mid_reset", 0, 0);
        check("mid_reset.id", 32'(id4), 0);
        reset = 1'b0;
        req5  = 5'b01111;
        cycle();
        expect4("post_reset", 4'b0001, 0);

        // Random bursts, locks and occasional resets, all DUTs against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 5; b++) begin
                if (req5[b]) begin
                    if ($urandom_range(0, 9) == 0) req5[b] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req5[b] = 1'b1;
                end
                if ($urandom_range(0, 15) == 0) lock5[b] = ~lock5[b];
            end
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Parametrised round-robin bus arbiter for N processing elements sharing one bus. Generalises the fixed 4-PE arbiter.
- Ownership is held across multi-cycle bursts.
- Hand-off to the next requester happens with no idle cycle.
- An optional hold limit forces rotation, and a per-requester lock suppresses that preemption.
- Sits between PE request lines and the shared memory/interconnect mux, which is steered by grant_id.

Parameters:
- NUM_REQ, 4, number of requesters; must be at least 2.
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the bus while others wait; 0 disables preemption.
- ID_W, $clog2(NUM_REQ), width of grant_id. Derived; not to be overridden.
- CNT_W, $clog2(MAX_HOLD+1) (minimum 1), width of the hold counter. Derived.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-PE request. Held high for the whole burst; dropped to release.
- lock  input  NUM_REQ  per-PE lock; while owner's bit is high, hold-limit preemption is suppressed.
- grant  output  NUM_REQ  one-hot (or zero) registered grant.
- grant_valid  output  1  high when grant is non-zero.
- grant_id  output  ID_W  index of the current owner; 0 when grant_valid is low.
- preempt  output  1  single-cycle pulse in the cycle after a forced hand-off.

Behaviour:
- Reset (synchronous, sampled at clk edge):
  - grant=0, grant_valid=0, grant_id=0, preempt=0.
  - Priority pointer ptr=0, hold_cnt=0, state=IDLE.
  - Reset asserted mid-burst drops the grant at that edge, with no completion.
- All outputs are registered. Latency from a req assertion to grant is one clock edge when the bus is idle.
- Arbitration function pick(mask):
  - Scans mask circularly starting at ptr: ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - Returns the first set index. Wrap is mod NUM_REQ.
- Granting to winner w:
  - grant is one-hot at w, grant_id=w.
  - ptr <= (w+1) mod NUM_REQ.
  - hold_cnt <= 1.
  - state=OWNED.
- State IDLE:
  - If req is non-zero: grant to pick(req).
  - Otherwise remain IDLE with outputs zero. ptr is unchanged.
- State OWNED, owner o (one branch per cycle, in this priority order):
  - Release when req[o]=0:
    - If req has any other bit set: grant to pick(req) at the same edge. This is back-to-back hand-off; preempt stays 0.
    - Otherwise grant <= 0 and state=IDLE.
  - Preempt when all of the following hold:
    - req[o]=1
    - MAX_HOLD != 0
    - hold_cnt == MAX_HOLD
    - lock[o]=0
    - req has some bit set other than o
    Action: grant to pick(req with bit o cleared), and preempt <= 1 for exactly one cycle.
  - Otherwise continue:
    - Grant unchanged.
    - hold_cnt increments, saturating at MAX_HOLD.
    - A sole requester keeps the bus indefinitely; no preemption without a contender.
- lock is sampled only for the current owner; lock bits of non-owners are ignored.
  - lock dropping while hold_cnt is already saturated triggers preemption at the next edge if a contender exists.
- Invariants:
  - grant is at most one-hot.
  - grant_valid equals the OR of grant.
  - grant is never given to an index whose req was 0 at the deciding edge.
- Fairness: with all requesters continuously active and lock=0, each requester is granted once per NUM_REQ bursts.
- When MAX_HOLD=0, hold_cnt is held at 0 and preempt never asserts.

Test Plan (NUM_REQ=4, MAX_HOLD=4 unless stated):
- Single requester: after reset, req=0010 → at the first edge grant=0010, grant_id=1, grant_valid=1. Grant is held for 10 cycles (no preempt). Drop req → grant=0000 at the next edge.
- Zero-gap hand-off: req=1111 → grant=0001. Drop req[0] → grant=0010 at the next edge with no idle cycle. Drop req[1] → 0100. Drop req[2] → 1000. Drop req[3] → 0001 (wrap).
- Preemption: req=0101 held and lock=0 → grant=0001 for exactly 4 cycles, then grant=0100 with a 1-cycle preempt pulse. After 4 more cycles grant=0001 with a preempt pulse.
- Lock: as above but lock=0001 → grant=0001 held for 20+ cycles with preempt=0. Clear lock[0] → grant=0100 at the next edge with a preempt pulse.
- Simultaneous release/request: owner 3 drops req[3] in the same cycle that req=0001 rises → grant=0001 at the next edge. Then req[3] re-asserts with req[0] held → grant stays 0001 until the hold limit is reached.
- Reset mid-burst: grant=0100 → assert reset for 1 cycle → all outputs 0. With req=1111 after reset → grant=0001 (ptr reset to 0). Also run NUM_REQ=5 and MAX_HOLD=0 regressions.
